// File: rtl/bist_response_sisr.sv
// -----------------------------------------------------------------------------
// bist_response_sisr
//
// Response compactor for a combinational circuit under test. It samples the
// circuit's single output bit once per applied pattern and folds it into a
// serial-input signature register (SISR). After PATTERN_COUNT responses the
// signature is compared against a golden value and a pass/fail verdict is
// held until the next session starts.
//
// Optional feature (compile-time macro SISR_XMASK_EN):
//   Adds input resp_mask and output x_count. A masked response feeds 0 into
//   the SISR instead of finalOutput and is counted in x_count. The default
//   build (macro undefined) compacts every accepted response unmasked.
//
// Ports:
//   clock          in   1          single clock, rising edge
//   reset_n        in   1          synchronous, active-low reset
//   start          in   1          begin a session (taken only in IDLE/DONE)
//   finalOutput    in   1          response bit from the circuit under test
//   resp_valid     in   1          finalOutput is valid this cycle
//   resp_mask      in   1          (SISR_XMASK_EN only) treat response as X
//   golden         in   SIG_WIDTH  expected signature, sampled in CHECK
//   ready          out  1          in RUN, responses accepted
//   busy           out  1          in RUN or CHECK
//   done           out  1          session complete, held until next start
//   pass           out  1          signature matched golden, valid with done
//   signature      out  SIG_WIDTH  current signature register
//   pattern_index  out  CNT_WIDTH  responses accepted this session
//   x_count        out  CNT_WIDTH  (SISR_XMASK_EN only) masked responses
// -----------------------------------------------------------------------------
module bist_response_sisr #(
    parameter int                   SIG_WIDTH     = 16,
    parameter logic [SIG_WIDTH-1:0] POLY          = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SEED          = 16'h0000,
    parameter int                   PATTERN_COUNT = 32,
    parameter int                   CNT_WIDTH     = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 finalOutput,
    input  logic                 resp_valid,
`ifdef SISR_XMASK_EN
    input  logic                 resp_mask,
    output logic [CNT_WIDTH-1:0] x_count,
`endif
    input  logic [SIG_WIDTH-1:0] golden,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [CNT_WIDTH-1:0] pattern_index
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index value of the final response of a session.
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PATTERN_COUNT - 1);

    state_t               state;
    logic                 feed_bit;
    logic [SIG_WIDTH-1:0] sig_next;

    // Bit actually shifted into the register; masked responses contribute 0.
`ifdef SISR_XMASK_EN
    assign feed_bit = finalOutput & ~resp_mask;
`else
    assign feed_bit = finalOutput;
`endif

    // One SISR step: shift left, apply polynomial feedback when the bit
    // leaving the top is 1, then XOR the response into bit 0.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        sig_next = {signature[SIG_WIDTH-2:0], 1'b0};
        if (signature[SIG_WIDTH-1]) begin
            sig_next = sig_next ^ POLY;
        end
        sig_next[0] = sig_next[0] ^ feed_bit;
    end

    assign ready = (state == RUN);
    assign busy  = (state == RUN) || (state == CHECK);

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, as hardware does.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            signature     <= SEED;
            pattern_index <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
`ifdef SISR_XMASK_EN
            x_count       <= '0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    // A response arriving with start is not compacted.
                    if (start) begin
                        state         <= RUN;
                        signature     <= SEED;
                        pattern_index <= '0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
`ifdef SISR_XMASK_EN
                        x_count       <= '0;
`endif
                    end
                end

                RUN: begin
                    if (resp_valid) begin
                        signature     <= sig_next;
                        pattern_index <= pattern_index + 1'b1;
`ifdef SISR_XMASK_EN
                        if (resp_mask) begin
                            x_count <= x_count + 1'b1;
                        end
`endif
                        // Index stops at PATTERN_COUNT: RUN is left on the
                        // same edge that accepts the last response.
                        if (pattern_index == LAST_IDX) begin
                            state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    pass  <= (signature == golden);
                    done  <= 1'b1;
                    state <= DONE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_response_sisr.sv
// -----------------------------------------------------------------------------
// tb_bist_response_sisr
//
// Self-checking bench for bist_response_sisr. A behavioural model keeps the
// list of accepted response bits and derives the expected signature from it;
// a compare process checks every DUT output against the model on each falling
// edge. Directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_bist_response_sisr;

    localparam int          W    = 16;
    localparam logic [15:0] POLY = 16'h1021;
    localparam logic [15:0] SEED = 16'h0000;
    localparam int          PC   = 32;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        finalOutput;
    logic        resp_valid;
    logic [15:0] golden;
    logic        ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [5:0]  pattern_index;
`ifdef SISR_XMASK_EN
    logic        resp_mask;
    logic [5:0]  x_count;
`endif

    int tests = 0;
    int fails = 0;
    bit cmp_en = 0;

    bist_response_sisr dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .finalOutput   (finalOutput),
        .resp_valid    (resp_valid),
`ifdef SISR_XMASK_EN
        .resp_mask     (resp_mask),
        .x_count       (x_count),
`endif
        .golden        (golden),
        .ready         (ready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .signature     (signature),
        .pattern_index (pattern_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Signature of the first n response bits of v (v[0] applied first),
    // starting from SEED and following the polynomial-division rule.
    function automatic logic [15:0] sig_of(input logic [31:0] v, input int n);
        logic [15:0] s;
        logic        top;
        s = SEED;
        for (int i = 0; i < n; i++) begin
            top = s[W-1];
            s   = s << 1;
            if (top) s = s ^ POLY;
            s[0] = s[0] ^ v[i];
        end
        return s;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_bits = '0;   // accepted responses in arrival order
    int          m_n    = 0;    // number accepted this session
    bit          m_run  = 0;    // responses are being collected
    bit          m_chk  = 0;    // verdict due on the next edge
    bit          m_done = 0;
    bit          m_pass = 0;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_bits <= '0;
            m_n    <= 0;
            m_run  <= 0;
            m_chk  <= 0;
            m_done <= 0;
            m_pass <= 0;
        end else if (m_chk) begin
            m_pass <= (sig_of(m_bits, m_n) == golden);
            m_done <= 1;
            m_chk  <= 0;
        end else if (m_run) begin
            if (resp_valid) begin
                m_bits[m_n] <= finalOutput;
                m_n         <= m_n + 1;
                if (m_n + 1 == PC) begin
                    m_run <= 0;
                    m_chk <= 1;
                end
            end
        end else if (start) begin
            m_bits <= '0;
            m_n    <= 0;
            m_done <= 0;
            m_pass <= 0;
            m_run  <= 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (cmp_en) begin
            check("cmp_signature", 32'(signature), 32'(sig_of(m_bits, m_n)));
            check("cmp_index", 32'(pattern_index), 32'(m_n));
            check("cmp_ready", 32'(ready), 32'(m_run));
            check("cmp_busy", 32'(busy), 32'(m_run | m_chk));
            check("cmp_done", 32'(done), 32'(m_done));
            check("cmp_pass", 32'(pass), 32'(m_pass));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic feed(input logic b);
        finalOutput = b;
        resp_valid  = 1'b1;
        cyc();
        resp_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 8 && !done; i++) cyc();
        check(name, 32'(done), 32'd1);
    endtask

    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] v3;

    initial begin
        v1 = 32'hA5C2_FFFF;   // 16 ones, a 0, then 15 arbitrary bits
        v2 = 32'h3C96_5A0F;
        v3 = 32'h0F1E_2D3C;
        reset_n     = 1'b0;
        start       = 1'b1;
        finalOutput = 1'b0;
        resp_valid  = 1'b0;
        golden      = sig_of(v1, PC);
`ifdef SISR_XMASK_EN
        resp_mask   = 1'b0;
`endif

        // Reset held two cycles with start asserted.
        repeat (2) cyc();
        check("rst_signature", 32'(signature), 32'h0000);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        cmp_en  = 1;
        start   = 1'b0;
        reset_n = 1'b1;
        cyc();
        check("idle_ready", 32'(ready), 32'd0);

        // Session 1: shift, feedback, gaps, ignored start, full compare.
        pulse_start();
        check("start_ready", 32'(ready), 32'd1);
        check("start_index", 32'(pattern_index), 32'd0);
        feed(1'b1);
        check("shift_1", 32'(signature), 32'h0001);
        feed(1'b1);
        check("shift_2", 32'(signature), 32'h0003);
        feed(1'b1);
        check("shift_3", 32'(signature), 32'h0007);
        check("shift_index", 32'(pattern_index), 32'd3);
        for (int i = 3; i < 16; i++) feed(1'b1);
        check("ones_16", 32'(signature), 32'hFFFF);
        feed(1'b0);
        check("feedback", 32'(signature), 32'hEFDF);
        check("feedback_index", 32'(pattern_index), 32'd17);

        repeat (5) cyc();
        check("gap_signature", 32'(signature), 32'hEFDF);
        check("gap_index", 32'(pattern_index), 32'd17);
        pulse_start();
        check("start_in_run_ready", 32'(ready), 32'd1);
        check("start_in_run_index", 32'(pattern_index), 32'd17);

        for (int i = 17; i < PC; i++) feed(v1[i]);
        check("last_accept_done", 32'(done), 32'd0);
        check("last_accept_busy", 32'(busy), 32'd1);
        check("last_accept_index", 32'(pattern_index), 32'd32);
        cyc();
        check("s1_done", 32'(done), 32'd1);
        check("s1_pass", 32'(pass), 32'd1);
        check("s1_signature", 32'(signature), 32'(sig_of(v1, PC)));

        // Responses while DONE are ignored.
        finalOutput = 1'b1;
        resp_valid  = 1'b1;
        repeat (3) cyc();
        resp_valid  = 1'b0;
        check("done_hold_signature", 32'(signature), 32'(sig_of(v1, PC)));
        check("done_hold_index", 32'(pattern_index), 32'd32);
        check("done_hold_done", 32'(done), 32'd1);

        // Session 2: wrong golden, restart straight from DONE with a
        // simultaneous response that must not be compacted.
        golden      = sig_of(v2, PC) ^ 16'h0001;
        finalOutput = 1'b1;
        resp_valid  = 1'b1;
        pulse_start();
        resp_valid  = 1'b0;
        check("restart_index", 32'(pattern_index), 32'd0);
        check("restart_signature", 32'(signature), 32'h0000);
        check("restart_done", 32'(done), 32'd0);
        for (int i = 0; i < PC; i++) feed(v2[i]);
        wait_done("s2_done");
        check("s2_pass", 32'(pass), 32'd0);
        check("s2_signature", 32'(signature), 32'(sig_of(v2, PC)));

        // Session 3: reset at pattern 10, then a fresh complete run.
        golden = sig_of(v3, PC);
        pulse_start();
        for (int i = 0; i < 10; i++) feed(v3[i]);
        check("pre_abort_index", 32'(pattern_index), 32'd10);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        check("abort_index", 32'(pattern_index), 32'd0);
        check("abort_signature", 32'(signature), 32'h0000);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        cyc();
        pulse_start();
        for (int i = 0; i < PC; i++) feed(v3[i]);
        wait_done("s3_done");
        check("s3_pass", 32'(pass), 32'd1);
        check("s3_signature", 32'(signature), 32'(sig_of(v3, PC)));
        repeat (2) cyc();

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
